cke_period_monitor: RTL and testbench

CKE_PERIOD_MONITOR -- requirements
Module: cke_period_monitor

---
 rtl/cke_period_monitor.sv | 139 +++++++++++++
 tb/tb_cke_period_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cke_period_monitor.sv
// Clock-enable period monitor: measures the spacing of iCke pulses, locks on a stable period,
// flags bad periods and missing pulses. Optional min/max outputs under `CKE_MON_MINMAX_EN`.
module cke_period_monitor #(
  parameter int pCntWidth = 16,
  parameter int pTol      = 2,
  parameter int pLockCnt  = 4
) (
  input  logic                 iSysClk,
  input  logic                 iSysRst,
  input  logic                 iEn,
  input  logic                 iCke,
  input  logic [pCntWidth-1:0] iExpect,
  input  logic                 iClr,
  output logic [pCntWidth-1:0] oPeriod,
  output logic                 oPeriodVld,
  output logic                 oLock,
  output logic                 oErr,
  output logic [7:0]           oMissCnt,
`ifdef CKE_MON_MINMAX_EN
  output logic [pCntWidth-1:0] oMinPeriod,
  output logic [pCntWidth-1:0] oMaxPeriod,
`endif
  output logic [1:0]           oState
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, TRACK = 2'd2, LOCK = 2'd3} state_t;

  localparam int W1 = pCntWidth + 1;
  localparam logic [7:0] cLockLast = 8'(pLockCnt - 1);

  state_t               state;
  logic [pCntWidth-1:0] rCnt;
  logic [7:0]           goodCnt;

  logic [pCntWidth:0] cntExt, expExt, diff, limit;
  logic               goodPeriod, timeout;
  logic [7:0]         missBase, missNext;

  // Deviation and timeout limit are evaluated one bit wider so neither can wrap.
  assign cntExt     = {1'b0, rCnt};
  assign expExt     = {1'b0, iExpect};
  assign diff       = (cntExt >= expExt) ? (cntExt - expExt) : (expExt - cntExt);
  assign goodPeriod = (diff <= W1'(pTol));
  assign limit      = expExt + W1'(pTol);
  assign timeout    = (cntExt == limit);

  // A miss on the same clock as iClr counts from zero.
  assign missBase = iClr ? 8'd0 : oMissCnt;
  assign missNext = (missBase == 8'hFF) ? 8'hFF : (missBase + 8'd1);

  assign oState = state;

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      state      <= IDLE;
      rCnt       <= '0;
      goodCnt    <= '0;
      oPeriod    <= '0;
      oPeriodVld <= 1'b0;
      oLock      <= 1'b0;
      oErr       <= 1'b0;
      oMissCnt   <= '0;
`ifdef CKE_MON_MINMAX_EN
      oMinPeriod <= '1;
      oMaxPeriod <= '0;
`endif
    end else begin
      oPeriodVld <= 1'b0;
      if (iClr) begin
        oErr     <= 1'b0;
        oMissCnt <= '0;
`ifdef CKE_MON_MINMAX_EN
        oMinPeriod <= '1;
        oMaxPeriod <= '0;
`endif
      end
      if (!iEn) begin
        state   <= IDLE;
        rCnt    <= '0;
        goodCnt <= '0;
        oLock   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (iCke && (iExpect != '0)) begin
              rCnt  <= pCntWidth'(1);
              state <= TRACK;
            end
          end
          default: begin
            if (iExpect == '0) begin
              state   <= ARM;
              rCnt    <= '0;
              goodCnt <= '0;
              oLock   <= 1'b0;
            end else if (iCke) begin
              oPeriod    <= rCnt;
              oPeriodVld <= 1'b1;
              rCnt       <= pCntWidth'(1);
`ifdef CKE_MON_MINMAX_EN
              oMinPeriod <= (iClr || (rCnt < oMinPeriod)) ? rCnt : oMinPeriod;
              oMaxPeriod <= (iClr || (rCnt > oMaxPeriod)) ? rCnt : oMaxPeriod;
`endif
              if (goodPeriod) begin
                if (state == TRACK) begin
                  if (goodCnt == cLockLast) begin
                    state <= LOCK;
                    oLock <= 1'b1;
                  end
                  goodCnt <= goodCnt + 8'd1;
                end
              end else begin
                goodCnt <= '0;
                if (state == LOCK) begin
                  oErr  <= 1'b1;
                  oLock <= 1'b0;
                  state <= TRACK;
                end
              end
            end else if (timeout) begin
              oMissCnt <= missNext;
              rCnt     <= pCntWidth'(1);
              goodCnt  <= '0;
              if (state == LOCK) begin
                oErr  <= 1'b1;
                oLock <= 1'b0;
                state <= TRACK;
              end
            end else if (rCnt != '1) begin
              rCnt <= rCnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cke_period_monitor.sv
// Bench for cke_period_monitor: expected periods queued by the pulse driver, popped on oPeriodVld;
// status outputs checked at scenario points. Min/max checks compile in with CKE_MON_MINMAX_EN.
module tb_cke_period_monitor;

  localparam int W = 16;

  logic         iSysClk = 1'b0;
  logic         iSysRst;
  logic         iEn, iCke, iClr;
  logic [W-1:0] iExpect;
  logic [W-1:0] oPeriod;
  logic         oPeriodVld, oLock, oErr;
  logic [7:0]   oMissCnt;
  logic [1:0]   oState;
`ifdef CKE_MON_MINMAX_EN
  logic [W-1:0] oMinPeriod, oMaxPeriod;
`endif

  logic [W-1:0] exp_q[$];
  int vecCnt = 0;
  int errCnt = 0;

  cke_period_monitor #(.pCntWidth(W), .pTol(2), .pLockCnt(4)) dut (
    .iSysClk(iSysClk), .iSysRst(iSysRst), .iEn(iEn), .iCke(iCke), .iExpect(iExpect),
    .iClr(iClr), .oPeriod(oPeriod), .oPeriodVld(oPeriodVld), .oLock(oLock), .oErr(oErr),
    .oMissCnt(oMissCnt),
`ifdef CKE_MON_MINMAX_EN
    .oMinPeriod(oMinPeriod), .oMaxPeriod(oMaxPeriod),
`endif
    .oState(oState)
  );

  // clock / reset
  always #5 iSysClk = ~iSysClk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecCnt++;
    if (obs !== expv) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge iSysClk);
    #1;
  endtask

  // iCke pulse whose rising edge lands gap clocks after the previous one; expP<0 = no report
  task automatic ckeAfter(input int gap, input int expP);
    if (expP >= 0) exp_q.push_back(W'(expP));
    iCke = 1'b0;
    repeat (gap - 1) tick();
    iCke = 1'b1;
    tick();
    iCke = 1'b0;
  endtask

  task automatic clrPulse();
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
  endtask

  // scoreboard
  always @(negedge iSysClk) begin
    if (oPeriodVld) begin
      if (exp_q.size() == 0) checkVal("spuriousVld", {16'd0, oPeriod}, 32'hFFFF_FFFF);
      else checkVal("period", {16'd0, oPeriod}, {16'd0, exp_q.pop_front()});
    end
  end

  initial begin
    iSysRst = 1'b1; iEn = 1'b0; iCke = 1'b0; iClr = 1'b0; iExpect = '0;
    repeat (2) tick();
    checkVal("rstState", oState, 0);
    checkVal("rstMiss", oMissCnt, 0);
    iSysRst = 1'b0;

    // steady 10-clock stream locks after the 4th reported period
    iEn = 1'b1; iExpect = W'(10);
    tick();
    checkVal("armState", oState, 1);
    ckeAfter(1, -1);
    checkVal("trackState", oState, 2);
    for (int i = 0; i < 4; i++) begin
      ckeAfter(10, 10);
      checkVal("lockRamp", oLock, (i == 3) ? 1 : 0);
    end
    checkVal("lockErr", oErr, 0);

    // tolerance edges: 12 on the timeout clock is a good pulse, 8 good, 7 bad
    ckeAfter(12, 12);
    checkVal("p12Lock", oLock, 1);
    checkVal("p12Miss", oMissCnt, 0);
    ckeAfter(8, 8);
    checkVal("p8Lock", oLock, 1);
    ckeAfter(7, 7);
    checkVal("p7Err", oErr, 1);
    checkVal("p7Lock", oLock, 0);
    checkVal("p7State", oState, 2);
    clrPulse();
    checkVal("clrErr", oErr, 0);
    ckeAfter(9, 10);
    for (int i = 0; i < 3; i++) ckeAfter(10, 10);
    checkVal("relock", oLock, 1);

    // 13-clock gap: timeout at 12, then the late pulse measures 1
    ckeAfter(13, 1);
    checkVal("gapErr", oErr, 1);
    checkVal("gapLock", oLock, 0);
    checkVal("gapMiss", oMissCnt, 1);
    for (int i = 0; i < 4; i++) ckeAfter(10, 10);
    checkVal("gapRelock", oLock, 1);
    checkVal("gapErrSticky", oErr, 1);

    // pulses stop: iClr on the timeout clock loses to the miss
    iCke = 1'b0;
    repeat (11) tick();
    clrPulse();
    checkVal("clrMissErr", oErr, 1);
    checkVal("clrMissCnt", oMissCnt, 1);
    checkVal("clrMissLock", oLock, 0);
    repeat (11) tick();
    checkVal("missEarly", oMissCnt, 1);
    tick();
    checkVal("miss2", oMissCnt, 2);
    repeat (120) tick();
    checkVal("miss12", oMissCnt, 12);
    repeat (12 * 250) tick();
    checkVal("missSat", oMissCnt, 255);
    repeat (12) tick();
    checkVal("missHold", oMissCnt, 255);
    clrPulse();
    checkVal("clrAllMiss", oMissCnt, 0);
    checkVal("clrAllErr", oErr, 0);

    // period 1 with iCke held high, then disable
    iEn = 1'b0;
    tick();
    checkVal("idleState", oState, 0);
    iExpect = W'(1); iEn = 1'b1;
    tick();
    iCke = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(W'(1));
      tick();
      checkVal("p1Lock", oLock, (i == 3) ? 1 : 0);
    end
    exp_q.push_back(W'(1));
    tick();
    iEn = 1'b0;
    tick();
    checkVal("offState", oState, 0);
    checkVal("offLock", oLock, 0);
    checkVal("offVld", oPeriodVld, 0);
    checkVal("offPeriodKept", {16'd0, oPeriod}, 1);
    iCke = 1'b0;

    // iExpect forced to 0 while tracking returns to ARM; next pulse only re-arms
    iExpect = W'(10); iEn = 1'b1;
    tick();
    ckeAfter(1, -1);
    ckeAfter(10, 10);
    iExpect = '0;
    tick();
    checkVal("exp0State", oState, 1);
    iExpect = W'(10);
    ckeAfter(5, -1);
    checkVal("rearmState", oState, 2);
    ckeAfter(10, 10);

    // min/max over 9, 11, 10
    clrPulse();
`ifdef CKE_MON_MINMAX_EN
    checkVal("clrMin", {16'd0, oMinPeriod}, 32'h0000_FFFF);
    checkVal("clrMax", {16'd0, oMaxPeriod}, 0);
`endif
    ckeAfter(8, 9);
    ckeAfter(11, 11);
    ckeAfter(10, 10);
`ifdef CKE_MON_MINMAX_EN
    checkVal("minP", {16'd0, oMinPeriod}, 9);
    checkVal("maxP", {16'd0, oMaxPeriod}, 11);
`endif

    // asynchronous reset in the middle of a period
    repeat (4) tick();
    #2;
    iSysRst = 1'b1;
    #1;
    checkVal("arstState", oState, 0);
    checkVal("arstPeriod", {16'd0, oPeriod}, 0);
    checkVal("arstLock", oLock, 0);
    checkVal("arstVld", oPeriodVld, 0);
    checkVal("arstErr", oErr, 0);
    checkVal("arstMiss", oMissCnt, 0);
`ifdef CKE_MON_MINMAX_EN
    checkVal("arstMin", {16'd0, oMinPeriod}, 32'h0000_FFFF);
    checkVal("arstMax", {16'd0, oMaxPeriod}, 0);
`endif
    tick();
    iSysRst = 1'b0;
    tick();
    checkVal("postRstArm", oState, 1);
    ckeAfter(3, -1);
    ckeAfter(10, 10);
    tick();

    checkVal("qDrained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
